egg_timer_ctrl: RTL and testbench

Central sequencer for the egg timer. Takes debounced button levels and mode switches, runs the INIT/TCONFIG/PAUSE/RESUME/DONE state machine, and owns the 12-bit seconds count. Generates the 1 Hz decrement tick from the system clock and drives the status LEDs. Sits between the debouncers and the display driver; `count` feeds the mm:ss seven-segment formatter.

---
 rtl/egg_timer_ctrl.sv | 156 +++++++++++++++
 tb/tb_egg_timer_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/egg_timer_ctrl.sv
// Egg timer sequencer: INIT/TCONFIG/PAUSE/RESUME/DONE state machine, 12-bit seconds
// count, 1 Hz countdown prescaler and alarm LED blinker.
module egg_timer_ctrl #(
    parameter int CLK_HZ       = 5000000,
    parameter int MAX_COUNT    = 3599,
    parameter int BLINK_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cook_time,
    input  logic        start,
    input  logic        mins,
    input  logic        secs,
    output logic [2:0]  state,
    output logic [11:0] count,
    output logic        LED_on,
    output logic        LED_en
);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_TCONFIG = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_RESUME  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);
    localparam logic [11:0]   MAX_CNT   = 12'(MAX_COUNT);

    state_e        state_q, state_d;
    logic [11:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          led_on_q, led_on_d;
    logic          led_en_q, led_en_d;
    logic          mins_q, secs_q;

    logic          mins_press, secs_press, tick;
    logic [5:0]    add_amt;
    logic [12:0]   cfg_sum;
    logic [11:0]   cfg_count;

    assign mins_press = mins & ~mins_q;
    assign secs_press = secs & ~secs_q;

    // Configured time saturates at MAX_COUNT instead of wrapping.
    assign add_amt   = (mins_press ? 6'd60 : 6'd0) + (secs_press ? 6'd1 : 6'd0);
    assign cfg_sum   = {1'b0, count_q} + {7'd0, add_amt};
    assign cfg_count = (cfg_sum > {1'b0, MAX_CNT}) ? MAX_CNT : cfg_sum[11:0];

    assign tick = (state_q == ST_RESUME) && (presc_q == PRESC_MAX);

    // NOTE: every register gets an explicit reset value here; there is no memory array,
    // so nothing is left to power-up state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update
        // together from the same pre-edge values.
        if (rst) begin
            state_q  <= ST_INIT;
            count_q  <= '0;
            presc_q  <= '0;
            blink_q  <= '0;
            led_on_q <= 1'b0;
            led_en_q <= 1'b0;
            mins_q   <= 1'b0;
            secs_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            blink_q  <= blink_d;
            led_on_q <= led_on_d;
            led_en_q <= led_en_d;
            mins_q   <= mins;
            secs_q   <= secs;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d  = state_q;
        count_d  = count_q;
        presc_d  = presc_q;
        blink_d  = blink_q;
        led_on_d = led_on_q;
        led_en_d = led_en_q;

        if (enable) begin
            case (state_q)
                ST_INIT: begin
                    if (cook_time) state_d = ST_TCONFIG;
                end
                ST_TCONFIG: begin
                    count_d = cfg_count;
                    if (!cook_time) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (cook_time)                       state_d = ST_TCONFIG;
                    else if (start && count_q != 12'd0) state_d = ST_RESUME;
                end
                ST_RESUME: begin
                    if (cook_time)   state_d = ST_TCONFIG;
                    else if (!start) state_d = ST_PAUSE;
                    else if (tick) begin
                        if (count_q <= 12'd1) begin
                            count_d = 12'd0;
                            state_d = ST_DONE;
                        end else begin
                            count_d = count_q - 12'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (cook_time)   state_d = ST_TCONFIG;
                    else if (!start) state_d = ST_INIT;
                end
                default: state_d = ST_INIT;
            endcase

            // Prescaler only runs while staying in RESUME; any entry or exit restarts the second.
            if (state_q == ST_RESUME && state_d == ST_RESUME)
                presc_d = tick ? '0 : presc_q + PW'(1);
            else
                presc_d = '0;

            if (state_d == ST_DONE) begin
                if (state_q != ST_DONE) begin
                    blink_d  = '0;
                    led_en_d = 1'b1;
                end else if (blink_q == BLINK_MAX) begin
                    blink_d  = '0;
                    led_en_d = ~led_en_q;
                end else begin
                    blink_d  = blink_q + BW'(1);
                end
            end else begin
                blink_d  = '0;
                led_en_d = 1'b0;
            end

            led_on_d = (state_d == ST_RESUME);
        end
    end

    assign state  = state_q;
    assign count  = count_q;
    assign LED_on = led_on_q;
    assign LED_en = led_en_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed testbench for egg_timer_ctrl with CLK_HZ=10 and BLINK_CYCLES=4; each task
// drives one scenario and compares against hand-computed values.
module tb_egg_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        cook_time = 1'b0;
    logic        start = 1'b0;
    logic        mins = 1'b0;
    logic        secs = 1'b0;
    logic [2:0]  state;
    logic [11:0] count;
    logic        LED_on;
    logic        LED_en;

    int errors = 0;
    int checks = 0;

    egg_timer_ctrl #(
        .CLK_HZ(10),
        .MAX_COUNT(3599),
        .BLINK_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .cook_time(cook_time),
        .start(start),
        .mins(mins),
        .secs(secs),
        .state(state),
        .count(count),
        .LED_on(LED_on),
        .LED_en(LED_en)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit so outputs are sampled off the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic m, input logic s);
        mins = m;
        secs = s;
        step(1);
        mins = 1'b0;
        secs = 1'b0;
        step(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cook_time = 1'b0;
        start = 1'b0;
        enable = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (count !== 12'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (LED_on !== 1'b0) begin errors++; $display("FAIL reset_led_on: got %0b expected 0", LED_on); end
        checks++; if (LED_en !== 1'b0) begin errors++; $display("FAIL reset_led_en: got %0b expected 0", LED_en); end
        press(1'b1, 1'b0);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL init_press_state: got %0d expected 0", state); end
        checks++; if (count !== 12'd0) begin errors++; $display("FAIL init_press_count: got %0d expected 0", count); end
    endtask

    task automatic test_config();
        cook_time = 1'b1;
        step(1);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL cfg_state: got %0d expected 1", state); end
        press(1'b1, 1'b0);
        checks++; if (count !== 12'd60) begin errors++; $display("FAIL cfg_mins: got %0d expected 60", count); end
        press(1'b0, 1'b1);
        checks++; if (count !== 12'd61) begin errors++; $display("FAIL cfg_secs: got %0d expected 61", count); end
        press(1'b1, 1'b1);
        checks++; if (count !== 12'd122) begin errors++; $display("FAIL cfg_both: got %0d expected 122", count); end
        // Held level must count as one press only.
        mins = 1'b1;
        step(4);
        mins = 1'b0;
        step(1);
        checks++; if (count !== 12'd182) begin errors++; $display("FAIL cfg_held: got %0d expected 182", count); end
    endtask

    task automatic test_saturate();
        // 182 + 56*60 + 48 = 3590
        for (int i = 0; i < 56; i++) press(1'b1, 1'b0);
        for (int i = 0; i < 48; i++) press(1'b0, 1'b1);
        checks++; if (count !== 12'd3590) begin errors++; $display("FAIL sat_setup: got %0d expected 3590", count); end
        press(1'b1, 1'b0);
        checks++; if (count !== 12'd3599) begin errors++; $display("FAIL sat_mins: got %0d expected 3599", count); end
        press(1'b0, 1'b1);
        checks++; if (count !== 12'd3599) begin errors++; $display("FAIL sat_secs: got %0d expected 3599", count); end
    endtask

    task automatic test_countdown();
        do_reset();
        cook_time = 1'b1;
        step(1);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
        cook_time = 1'b0;
        step(1);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL cd_pause: got %0d expected 2", state); end
        start = 1'b1;
        step(1);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL cd_resume: got %0d expected 3", state); end
        checks++; if (LED_on !== 1'b1) begin errors++; $display("FAIL cd_led_on: got %0b expected 1", LED_on); end
        step(9);
        checks++; if (count !== 12'd3) begin errors++; $display("FAIL cd_plus9: got %0d expected 3", count); end
        step(1);
        checks++; if (count !== 12'd2) begin errors++; $display("FAIL cd_plus10: got %0d expected 2", count); end
        step(10);
        checks++; if (count !== 12'd1) begin errors++; $display("FAIL cd_plus20: got %0d expected 1", count); end
        step(10);
        checks++; if (count !== 12'd0) begin errors++; $display("FAIL cd_plus30_count: got %0d expected 0", count); end
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL cd_done_state: got %0d expected 4", state); end
        checks++; if (LED_en !== 1'b1) begin errors++; $display("FAIL cd_blink0: got %0b expected 1", LED_en); end
        checks++; if (LED_on !== 1'b0) begin errors++; $display("FAIL cd_done_led_on: got %0b expected 0", LED_on); end
        step(3);
        checks++; if (LED_en !== 1'b1) begin errors++; $display("FAIL cd_blink3: got %0b expected 1", LED_en); end
        step(1);
        checks++; if (LED_en !== 1'b0) begin errors++; $display("FAIL cd_blink4: got %0b expected 0", LED_en); end
        step(4);
        checks++; if (LED_en !== 1'b1) begin errors++; $display("FAIL cd_blink8: got %0b expected 1", LED_en); end
        start = 1'b0;
        step(1);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL cd_to_init: got %0d expected 0", state); end
        checks++; if (LED_en !== 1'b0) begin errors++; $display("FAIL cd_init_led_en: got %0b expected 0", LED_en); end
    endtask

    task automatic test_pause_resume();
        do_reset();
        cook_time = 1'b1;
        step(1);
        for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
        cook_time = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        step(7);
        start = 1'b0;
        step(1);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL pr_pause: got %0d expected 2", state); end
        checks++; if (count !== 12'd5) begin errors++; $display("FAIL pr_pause_count: got %0d expected 5", count); end
        checks++; if (LED_on !== 1'b0) begin errors++; $display("FAIL pr_pause_led: got %0b expected 0", LED_on); end
        start = 1'b1;
        step(1);
        step(9);
        checks++; if (count !== 12'd5) begin errors++; $display("FAIL pr_partial_discard: got %0d expected 5", count); end
        step(1);
        checks++; if (count !== 12'd4) begin errors++; $display("FAIL pr_first_dec: got %0d expected 4", count); end
        step(3);
        enable = 1'b0;
        start = 1'b0;
        step(20);
        checks++; if (count !== 12'd4) begin errors++; $display("FAIL pr_freeze_count: got %0d expected 4", count); end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL pr_freeze_state: got %0d expected 3", state); end
        start = 1'b1;
        enable = 1'b1;
        step(6);
        checks++; if (count !== 12'd4) begin errors++; $display("FAIL pr_presc_hold: got %0d expected 4", count); end
        step(1);
        checks++; if (count !== 12'd3) begin errors++; $display("FAIL pr_after_freeze: got %0d expected 3", count); end
    endtask

    task automatic test_reset_midrun();
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", state); end
        checks++; if (count !== 12'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", count); end
        checks++; if (LED_on !== 1'b0) begin errors++; $display("FAIL rst_mid_led_on: got %0b expected 0", LED_on); end
        start = 1'b0;
        cook_time = 1'b1;
        step(1);
        cook_time = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL zero_start: got %0d expected 2", state); end
        step(3);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL zero_start_hold: got %0d expected 2", state); end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_config();
        test_saturate();
        test_countdown();
        test_pause_resume();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
